monit_buf_sched: RTL
====================

// Module: monit_buf_sched
// PURPOSE
//  Write/read scheduler in front of one dataBuffer instance in the monitoring path.
//  Round-robin arbitrates NUM_CH measurement producers onto the single buffer write port.
//  Sequences buffer reads towards one downstream consumer through a valid/ready handshake.
//  dataBuffer exports no full/empty flags, so this block keeps an exact shadow occupancy count.
// PARAMETERS
//  NUM_CH               4   number of producer channels (2..8)
//  BUFFER_LENGTH        32  depth of the controlled dataBuffer; must equal its BUFFER_LENGTH
//  CNT_WIDTH            6   occupancy counter width; must hold the value BUFFER_LENGTH
//  VARIABLE_LENGTH_BITS 32  word width
// PORTS
//  clk          in   1          system clock, all logic on posedge
//  rst          in   1          asynchronous, active-high reset
//  ch_req       in   NUM_CH     per-channel write request, level
//  ch_data      in   NUM_CH*W   channel i word at [i*W +: W], W=VARIABLE_LENGTH_BITS
//  ch_grant     out  NUM_CH     one-hot, 1-cycle pulse: word of that channel taken
//  buf_wr_enable out 1          to dataBuffer wr_enable
//  buf_in       out  W          to dataBuffer buf_in
//  buf_rd_enable out 1          to dataBuffer rd_enable
//  buf_out      in   W          from dataBuffer buf_out
//  rd_valid     out  1          rd_data valid to consumer
//  rd_ready     in   1          consumer accepts rd_data
//  rd_data      out  W          word to consumer (= buf_out while rd_valid)
//  occupancy    out  CNT_WIDTH  shadow word count
//  full / empty out  1          occupancy==BUFFER_LENGTH / occupancy==0
// BEHAVIOUR
//  Reset: all outputs 0 except empty=1; rr pointer last=NUM_CH-1 (ch0 highest priority);
//   read FSM in RD_IDLE. dataBuffer shares the same rst, so both sides clear together.
//  Commit: occ_next = occupancy + buf_wr_enable - buf_rd_enable. This is the dataBuffer
//   count after the current edge; write+read in the same cycle holds the count.
//  Write arbitration, evaluated every edge:
//   eligible = ch_req & ~ch_grant (a channel granted last cycle is masked for one cycle).
//   If eligible!=0 and occ_next < BUFFER_LENGTH:
//    grant the first eligible channel after last; register buf_in=ch_data[g];
//    set buf_wr_enable=1, ch_grant[g]=1, last=g.
//   Otherwise buf_wr_enable=0, ch_grant=0, and buf_in holds its value.
//   Producer holds ch_data stable while ch_req=1 and no grant is seen.
//   On the edge where it sees ch_grant, the producer may drop req or present the next word.
//   This gives a sustained rate of 1 word per 2 cycles per channel and 1 word per cycle in total.
//  Read FSM:
//   RD_IDLE  -> RD_ISSUE when occ_next > 0; buf_rd_enable=1 for exactly one cycle.
//   RD_ISSUE -> RD_DATA; rd_valid=1 (buf_out updated at this edge).
//   RD_DATA  stays while !rd_ready, with rd_valid and rd_data stable.
//            On rd_ready -> RD_IDLE, rd_valid=0.
//   Read throughput is 1 word per 3 cycles. Latency from first write commit to rd_valid is 2 edges.
//  Boundaries:
//   full: no grant is issued while occ_next==BUFFER_LENGTH; requests wait, no drops.
//   empty: no read is issued, so dataBuffer is never read while empty.
//   A read and a write committing at full do not free a write slot that cycle
//    (dataBuffer gates writes on its pre-edge count).
//   Pointer wrap of dataBuffer is transparent here.
//   rst asserted mid-operation: immediate clear, and in-flight words are discarded.
//  Invariant: occupancy equals the internal count of dataBuffer at every edge;
//   occupancy never exceeds BUFFER_LENGTH.
// STRUCTURE
//  monit_buf_pkg holds:
//   rd_state_t {RD_IDLE, RD_ISSUE, RD_DATA};
//   clog2 function;
//   CH_MAX=8 constant.
//  Sub-module rr_arbiter (NUM_CH): combinational round-robin pick from eligible and last,
//   outputs a one-hot grant and its index. The rest is flat in monit_buf_sched.
// TESTING (bench instantiates monit_buf_sched + dataBuffer, BUFFER_LENGTH=32)
//  1. ch0 single word 0xA5A5_0001, rd_ready=1 -> ch_grant=0001 1 cycle after req.
//     rd_valid follows 2 edges after the write commit with rd_data=0xA5A5_0001; empty=1 at end.
//  2. ch0..ch3 req continuously, rd_ready=0 ->
//     grants in order 0,1,2,3,0,... with no channel granted on consecutive cycles.
//     full=1 after 32 commits; no further grants.
//  3. From full, pulse rd_ready -> each accepted read frees one slot.
//     The next grant goes to the next rr channel; occupancy never exceeds 32.
//  4. Continuous writes and reads near 31/32 occupancy -> buffer-side count equals occupancy every cycle.
//     Read order equals write order; no lost or duplicated words.
//  5. rst high while in RD_DATA and occupancy=17 ->
//     same-cycle rd_valid=0, occupancy=0, empty=1, ch_grant=0; ch0 is highest priority afterwards.

Source files
------------

// File: rtl/monit_buf_pkg.sv
// Shared types and helpers for the monitoring-path buffer scheduler.
package monit_buf_pkg;

  localparam int CH_MAX = 8;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DATA  = 2'd2
  } rd_state_t;

  // Index width for n items; never below 1 so a 1-bit index still exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible channel after the last winner.
module rr_arbiter
  import monit_buf_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] eligible,
  input  logic [IDX_W-1:0]  last,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [IDX_W-1:0] idx;

  // Scan farthest-first so the nearest eligible channel after last wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = IDX_W'((int'(last) + i) % NUM_CH);
      if (eligible[idx]) begin
        grant       = '0;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/monit_buf_sched.sv
// Write/read scheduler in front of one dataBuffer: round-robin write arbitration,
// single-outstanding read sequencing and an exact shadow occupancy count.
module monit_buf_sched
  import monit_buf_pkg::*;
#(
  parameter int NUM_CH               = 4,
  parameter int BUFFER_LENGTH        = 32,
  parameter int CNT_WIDTH            = 6,
  parameter int VARIABLE_LENGTH_BITS = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CH-1:0]                      ch_req,
  input  logic [NUM_CH*VARIABLE_LENGTH_BITS-1:0] ch_data,
  output logic [NUM_CH-1:0]                      ch_grant,
  output logic                                   buf_wr_enable,
  output logic [VARIABLE_LENGTH_BITS-1:0]        buf_in,
  output logic                                   buf_rd_enable,
  input  logic [VARIABLE_LENGTH_BITS-1:0]        buf_out,
  output logic                                   rd_valid,
  input  logic                                   rd_ready,
  output logic [VARIABLE_LENGTH_BITS-1:0]        rd_data,
  output logic [CNT_WIDTH-1:0]                   occupancy,
  output logic                                   full,
  output logic                                   empty,
  output rd_state_t                              rd_state
);

  localparam int IDX_W = clog2(NUM_CH);

  logic [CNT_WIDTH-1:0]            occ_next;
  logic [NUM_CH-1:0]               eligible;
  logic [NUM_CH-1:0]               arb_grant;
  logic [IDX_W-1:0]                arb_idx;
  logic [IDX_W-1:0]                last;
  logic                            arb_valid;
  logic                            wr_ok;
  logic [VARIABLE_LENGTH_BITS-1:0] sel_word;

  // Count dataBuffer will hold after the coming edge.
  assign occ_next = occupancy + CNT_WIDTH'(buf_wr_enable) - CNT_WIDTH'(buf_rd_enable);
  assign eligible = ch_req & ~ch_grant;
  assign wr_ok    = arb_valid && (occ_next < CNT_WIDTH'(BUFFER_LENGTH));
  assign full     = (occupancy == CNT_WIDTH'(BUFFER_LENGTH));
  assign empty    = (occupancy == '0);

  // Consumer handshake: rd_valid rises with a fresh word, rd_data stays stable while
  // rd_valid && !rd_ready, and the word is consumed on an edge with rd_valid && rd_ready.
  assign rd_data  = rd_valid ? buf_out : '0;

  rr_arbiter #(
    .NUM_CH(NUM_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .eligible   (eligible),
    .last       (last),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_idx == IDX_W'(i)) sel_word = ch_data[i*VARIABLE_LENGTH_BITS +: VARIABLE_LENGTH_BITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy     <= '0;
      buf_wr_enable <= 1'b0;
      buf_in        <= '0;
      ch_grant      <= '0;
      last          <= IDX_W'(NUM_CH - 1);
    end else begin
      occupancy <= occ_next;
      if (wr_ok) begin
        buf_wr_enable <= 1'b1;
        buf_in        <= sel_word;
        ch_grant      <= arb_grant;
        last          <= arb_idx;
      end else begin
        buf_wr_enable <= 1'b0;
        ch_grant      <= '0;
      end
    end
  end

  // One read in flight at a time, so occ_next seen in RD_IDLE is never reduced by a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state      <= RD_IDLE;
      buf_rd_enable <= 1'b0;
      rd_valid      <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (occ_next != '0) begin
            rd_state      <= RD_ISSUE;
            buf_rd_enable <= 1'b1;
          end
        end
        RD_ISSUE: begin
          rd_state      <= RD_DATA;
          buf_rd_enable <= 1'b0;
          rd_valid      <= 1'b1;
        end
        RD_DATA: begin
          if (rd_ready) begin
            rd_state <= RD_IDLE;
            rd_valid <= 1'b0;
          end
        end
        default: begin
          rd_state      <= RD_IDLE;
          buf_rd_enable <= 1'b0;
          rd_valid      <= 1'b0;
        end
      endcase
    end
  end

endmodule
